// File: rtl/fan_pwm_counter.sv
//==============================================================================
// Module   : fan_pwm_counter
// Brief    : Free-running period counter with multi-channel PWM compare and
//            wrap-synchronised (double-buffered) period/duty updates.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fan_pwm_counter #(
   parameter int WIDTH          = 10,
   parameter int CHANNELS       = 3,
   parameter int DEFAULT_PERIOD = 1000
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_load,
   input  logic [WIDTH-1:0]          i_period,
   input  logic [CHANNELS*WIDTH-1:0] i_duty,
   output logic [WIDTH-1:0]          o_counter,
   output logic                      o_wrap,
   output logic                      o_load_ack,
   output logic [CHANNELS-1:0]       o_pwm
);

   localparam logic [WIDTH-1:0] c_default_period = WIDTH'(DEFAULT_PERIOD);
   localparam logic [WIDTH-1:0] c_min_period     = WIDTH'(2);
   localparam logic [WIDTH-1:0] c_one            = WIDTH'(1);

   logic [WIDTH-1:0]          counter_q, counter_d;
   logic [WIDTH-1:0]          period_q, period_d;
   logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
   logic [WIDTH-1:0]          pend_period_q, pend_period_d;
   logic [CHANNELS*WIDTH-1:0] pend_duty_q, pend_duty_d;
   logic                      pend_q, pend_d;
   logic                      ack_q, ack_d;

   logic                      w_wrap;
   logic                      w_apply;
   logic [WIDTH-1:0]          w_load_period;

   assign w_wrap        = i_enable && (counter_q == (period_q - c_one));
   assign w_apply       = w_wrap && pend_q;
   assign w_load_period = (i_period < c_min_period) ? c_min_period : i_period;

   // Apply happens before capture so a load on the wrap edge stays pending.
   always_comb begin
      counter_d     = counter_q;
      period_d      = period_q;
      duty_d        = duty_q;
      pend_period_d = pend_period_q;
      pend_duty_d   = pend_duty_q;
      pend_d        = pend_q;
      ack_d         = w_apply;

      if (i_enable) begin
         counter_d = w_wrap ? '0 : (counter_q + c_one);
      end

      if (w_apply) begin
         period_d = pend_period_q;
         duty_d   = pend_duty_q;
         pend_d   = 1'b0;
      end

      if (i_load) begin
         pend_period_d = w_load_period;
         pend_duty_d   = i_duty;
         pend_d        = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         counter_q     <= '0;
         period_q      <= c_default_period;
         duty_q        <= '0;
         pend_period_q <= '0;
         pend_duty_q   <= '0;
         pend_q        <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         counter_q     <= counter_d;
         period_q      <= period_d;
         duty_q        <= duty_d;
         pend_period_q <= pend_period_d;
         pend_duty_q   <= pend_duty_d;
         pend_q        <= pend_d;
         ack_q         <= ack_d;
      end
   end

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_pwm
         assign o_pwm[k] = i_enable && (counter_q < duty_q[k*WIDTH +: WIDTH]);
      end
   endgenerate

   assign o_counter  = counter_q;
   assign o_wrap     = w_wrap;
   assign o_load_ack = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_fan_pwm_counter.sv
//==============================================================================
// Module   : tb_fan_pwm_counter
// Brief    : Directed bench for fan_pwm_counter with hand-computed expectations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fan_pwm_counter;

   localparam int WIDTH    = 10;
   localparam int CHANNELS = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      en;
   logic                      ld;
   logic [WIDTH-1:0]          per;
   logic [CHANNELS*WIDTH-1:0] duty;
   logic [WIDTH-1:0]          cnt;
   logic                      wrap;
   logic                      ack;
   logic [CHANNELS-1:0]       pwm;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fan_pwm_counter #(
      .WIDTH          (WIDTH),
      .CHANNELS       (CHANNELS),
      .DEFAULT_PERIOD (1000)
   ) u_dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_enable   (en),
      .i_load     (ld),
      .i_period   (per),
      .i_duty     (duty),
      .o_counter  (cnt),
      .o_wrap     (wrap),
      .o_load_ack (ack),
      .o_pwm      (pwm)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input int c, input logic w, input logic a,
                     input logic [2:0] p);
      chk({tag, ".cnt"}, 32'(cnt), 32'(c));
      chk({tag, ".wrap"}, 32'(wrap), 32'(w));
      chk({tag, ".ack"}, 32'(ack), 32'(a));
      chk({tag, ".pwm"}, 32'(pwm), 32'(p));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Duty arguments are given channel 2 first, matching the packed layout.
   task automatic load(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d2,
                       input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d0);
      ld   = 1'b1;
      per  = p;
      duty = {d2, d1, d0};
      cyc(1);
      ld   = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      ld   = 1'b0;
      per  = '0;
      duty = '0;
      cyc(2);
      st("rst", 0, 1'b0, 1'b0, 3'b000);
      en = 1'b1;
      #1;
      st("rst_en", 0, 1'b0, 1'b0, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Default period 1000 free run
      for (int i = 0; i < 1000; i++) begin
         chk("s1.cnt", 32'(cnt), 32'(i));
         chk("s1.wrap", 32'(wrap), 32'(i == 999));
         chk("s1.pwm", 32'(pwm), 32'(0));
         if (i < 999) cyc(1);
      end
      cyc(1);
      st("s1.rollover", 0, 1'b0, 1'b0, 3'b000);

      // Load period 10 mid-period; takes effect only at the wrap
      cyc(500);
      load(10'd10, 10'd10, 10'd5, 10'd0);
      st("s2.after_load", 501, 1'b0, 1'b0, 3'b000);
      cyc(498);
      st("s2.term", 999, 1'b1, 1'b0, 3'b000);
      cyc(1);
      chk("s2.ack", 32'(ack), 32'(1));
      for (int i = 0; i < 10; i++) begin
         chk("s2.cnt", 32'(cnt), 32'(i));
         chk("s2.wrap", 32'(wrap), 32'(i == 9));
         chk("s2.pwm", 32'(pwm), 32'({1'b1, (i < 5), 1'b0}));
         if (i > 0) chk("s2.ack_once", 32'(ack), 32'(0));
         cyc(1);
      end
      st("s2.rollover", 0, 1'b0, 1'b0, 3'b110);

      // Two loads before one wrap: latest wins, single ack
      load(10'd8, 10'd8, 10'd4, 10'd0);
      load(10'd6, 10'd6, 10'd3, 10'd1);
      cyc(7);
      st("s3.term10", 9, 1'b1, 1'b0, 3'b100);
      cyc(1);
      st("s3.apply", 0, 1'b0, 1'b1, 3'b111);
      cyc(1);
      st("s3.after", 1, 1'b0, 1'b0, 3'b110);
      cyc(4);
      st("s3.term6", 5, 1'b1, 1'b0, 3'b100);
      cyc(1);
      st("s3.no_2nd_ack", 0, 1'b0, 1'b0, 3'b111);

      // Enable low at count 3 with a pending load
      load(10'd7, 10'd7, 10'd0, 10'd3);
      cyc(2);
      en = 1'b0;
      #1;
      st("s5.hold0", 3, 1'b0, 1'b0, 3'b000);
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         st("s5.hold", 3, 1'b0, 1'b0, 3'b000);
      end
      en = 1'b1;
      #1;
      st("s5.resume", 3, 1'b0, 1'b0, 3'b100);
      cyc(1);
      st("s5.cnt4", 4, 1'b0, 1'b0, 3'b100);
      cyc(1);
      st("s5.term", 5, 1'b1, 1'b0, 3'b100);
      cyc(1);
      st("s5.apply", 0, 1'b0, 1'b1, 3'b101);
      cyc(6);
      st("s5.term7", 6, 1'b1, 1'b0, 3'b100);

      // Load coincident with wrap while nothing pending
      load(10'd4, 10'd4, 10'd2, 10'd0);
      st("s4.wrap_load", 0, 1'b0, 1'b0, 3'b101);
      cyc(6);
      st("s4.term7", 6, 1'b1, 1'b0, 3'b100);
      cyc(1);
      st("s4.apply", 0, 1'b0, 1'b1, 3'b110);
      cyc(3);
      st("s4.term4", 3, 1'b1, 1'b0, 3'b100);
      cyc(1);
      st("s4.rollover", 0, 1'b0, 1'b0, 3'b110);

      // Period 0 clamps to 2
      load(10'd0, 10'd0, 10'd0, 10'd1);
      cyc(2);
      st("s6.term4", 3, 1'b1, 1'b0, 3'b100);
      cyc(1);
      st("s6.apply", 0, 1'b0, 1'b1, 3'b001);
      cyc(1);
      st("s6.p2_1", 1, 1'b1, 1'b0, 3'b000);
      cyc(1);
      st("s6.p2_0", 0, 1'b0, 1'b0, 3'b001);
      cyc(1);
      st("s6.p2_1b", 1, 1'b1, 1'b0, 3'b000);
      load(10'd9, 10'd9, 10'd9, 10'd9);
      st("s6.pend", 0, 1'b0, 1'b0, 3'b001);
      cyc(1);
      st("s6.pre_rst", 1, 1'b1, 1'b0, 3'b000);

      // Reset mid-period with a pending set
      rst = 1'b1;
      #1;
      st("s6.rst_async", 0, 1'b0, 1'b0, 3'b000);
      cyc(3);
      st("s6.rst_hold", 0, 1'b0, 1'b0, 3'b000);
      rst = 1'b0;
      #1;
      st("s6.rst_rel", 0, 1'b0, 1'b0, 3'b000);
      cyc(1);
      st("s6.first", 1, 1'b0, 1'b0, 3'b000);
      cyc(998);
      st("s6.term1000", 999, 1'b1, 1'b0, 3'b000);
      cyc(1);
      st("s6.no_ack", 0, 1'b0, 1'b0, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fan_pwm_counter.md
FAN_PWM_COUNTER -- requirements
Module: fan_pwm_counter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  WIDTH           10    counter, period and duty width in bits
  CHANNELS        3     number of independent PWM outputs
  DEFAULT_PERIOD  1000  active period after reset; range 2..2^WIDTH-1
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  i_clk       in   1                 clock, rising edge
  i_reset     in   1                 reset, asynchronous, active-high
  i_enable    in   1                 count enable
  i_load      in   1                 one-cycle request to capture i_period/i_duty
  i_period    in   WIDTH             requested period in clocks
  i_duty      in   CHANNELS*WIDTH    requested duty per channel; channel k at bits [k*WIDTH +: WIDTH]
  o_counter   out  WIDTH             current count value
  o_wrap      out  1                 one-cycle pulse on the terminal count
  o_load_ack  out  1                 one-cycle pulse when pending values become active
  o_pwm       out  CHANNELS          PWM outputs

Function
REQ-003 Active set: period P and duties D[k]. Pending set: period, duties and a pending flag.
REQ-004 With i_enable=1, o_counter SHALL count 0,1,...,P-1, then return to 0 on the next clock.
REQ-005 With i_enable=0, o_counter SHALL hold. Counting SHALL resume from the held value when enable returns.
REQ-006 o_wrap SHALL be combinational and high exactly when i_enable=1 and o_counter==P-1.
REQ-007 On a clock edge with i_load=1, the block SHALL copy i_period and i_duty into the pending set and set the pending flag.
REQ-008 If the pending flag is already set, a new i_load SHALL overwrite the pending set; the latest load wins and no ack is issued for the overwritten one.
REQ-009 On a clock edge with o_wrap=1 and the pending flag set:
  - the active set SHALL take the pending set;
  - the pending flag SHALL clear;
  - o_load_ack SHALL be 1 for exactly the following cycle (registered).
REQ-010 If i_load=1 on the same edge as o_wrap=1:
  - any previously pending set SHALL be applied;
  - the new values SHALL become pending for the next wrap;
  - the new values SHALL NOT be applied at this wrap.
REQ-011 If i_load=1 on a wrap edge while nothing is pending, the new values SHALL become pending only; there SHALL be no ack.
REQ-012 A loaded period below 2 SHALL be clamped to 2 when captured.
REQ-013 Active values SHALL never change except at a wrap edge or reset, so there are no mid-period glitches.
REQ-014 o_pwm[k] SHALL be combinational from registered state: i_enable && (o_counter < D[k]).
  - D[k]=0 gives constant low.
  - D[k]>=P gives constant high while enabled.
REQ-015 Comparisons SHALL be unsigned, WIDTH bits. The counter SHALL never exceed P-1 and has no overflow path.
REQ-016 The pending flag SHALL persist while i_enable=0. It SHALL be applied at the first wrap after enable returns.

Reset
REQ-017 While i_reset=1, the following SHALL be forced asynchronously:
  - o_counter=0
  - P=DEFAULT_PERIOD
  - all D[k]=0
  - pending flag clear, pending values 0
  - o_load_ack=0
REQ-018 During reset, o_pwm and o_wrap SHALL follow REQ-014 and REQ-006 from the reset state: o_pwm all 0, o_wrap 0.
REQ-019 A reset mid-period or mid-pending SHALL discard pending values without an ack. Counting SHALL restart from 0 on the first enabled clock after reset release.

Verification
REQ-020 Directed scenarios; the bench SHALL cover all of the following:
  - Reset, i_enable=1, no load: o_counter runs 0..999 then 0; o_wrap pulses every 1000 clocks at count 999; o_pwm=000.
  - Load period 10, duties {0,5,10} at count 500: no change until count 999. After the wrap, period is 10; o_pwm[0] always 0, o_pwm[1] high on counts 0-4, o_pwm[2] always high. o_load_ack pulses once, the cycle after the wrap.
  - Two loads (period 8, then 6) before one wrap: only 6 is applied; a single ack is issued.
  - Load coincident with the wrap (period 4 at count P-1, nothing pending): no ack at that wrap; period becomes 4 at the following wrap, with its ack.
  - i_enable=0 at count 3 for 20 clocks: counter holds 3, o_pwm=000, o_wrap=0. Counting resumes at 4. A pending load survives and applies at the next wrap.
  - Load period 0: clamped to 2, so the counter alternates 0,1 and o_wrap fires every 2nd clock. Assert i_reset mid-period: counter 0, period 1000, no ack.
